// File: rtl/stepper_cpu_oci_dct_capture.sv
// rtl/stepper_cpu_oci_dct_capture.sv - OCI DCT trace capture FIFO with flush, abort and overflow reporting
// Optional per-entry cycle timestamp: define OCI_CAPTURE_TIMESTAMP_EN.
module stepper_cpu_oci_dct_capture #(
    parameter int FRAME_W = 30,
    parameter int COUNT_W = 4,
    parameter int DEPTH   = 16,
`ifdef OCI_CAPTURE_TIMESTAMP_EN
    localparam int TS_W   = 16,
`else
    localparam int TS_W   = 0,
`endif
    localparam int E      = COUNT_W + FRAME_W + TS_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [FRAME_W-1:0]       dct_buffer,
    input  logic [COUNT_W-1:0]       dct_count,
    input  logic                     dct_valid,
    input  logic                     test_ending,
    input  logic                     test_has_ended,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [E-1:0]             rd_data,
    output logic                     rd_last,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        FLUSH   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [E-1:0]    mem [DEPTH];
    logic [E-1:0]    wr_entry;

    logic            full;
    logic            wr_req;
    logic            pop;
    logic            wr_ok;
    logic            wr_drop;

`ifdef OCI_CAPTURE_TIMESTAMP_EN
    logic [15:0]     ts;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ts <= 16'd0;
        else
            ts <= ts + 16'd1;
    end

    assign wr_entry = {ts, dct_count, dct_buffer};
`else
    assign wr_entry = {dct_count, dct_buffer};
`endif

    assign full     = (fill_level == FULL_LVL);
    assign rd_valid = (fill_level != '0) && (state != DONE);
    assign rd_last  = rd_valid && (state == FLUSH) && (fill_level == (AW+1)'(1));
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Abort wins over everything, so it gates both the read and write sides.
    assign pop     = rd_valid && rd_ready && !test_has_ended;
    assign wr_req  = (state == CAPTURE) && !test_has_ended && dct_valid && (dct_count != '0);
    assign wr_ok   = wr_req && (!full || pop);
    assign wr_drop = wr_req && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
            done       <= 1'b0;
        end else if (state != DONE) begin
            if (test_has_ended) begin
                state      <= DONE;
                done       <= 1'b1;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_level <= '0;
            end else begin
                if (wr_ok)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (wr_ok && !pop)
                    fill_level <= fill_level + (AW+1)'(1);
                else if (!wr_ok && pop)
                    fill_level <= fill_level - (AW+1)'(1);
                if (wr_drop) begin
                    overflow <= 1'b1;
                    if (drop_count != 8'hFF)
                        drop_count <= drop_count + 8'd1;
                end
                case (state)
                    CAPTURE: if (test_ending) state <= FLUSH;
                    FLUSH: begin
                        if (fill_level == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stepper_cpu_oci_dct_capture.sv
// tb/tb_stepper_cpu_oci_dct_capture.sv - randomized self-checking bench for stepper_cpu_oci_dct_capture
module tb_stepper_cpu_oci_dct_capture;

    localparam int FRAME_W = 30;
    localparam int COUNT_W = 4;
    localparam int DEPTH   = 16;
`ifdef OCI_CAPTURE_TIMESTAMP_EN
    localparam int E = COUNT_W + FRAME_W + 16;
`else
    localparam int E = COUNT_W + FRAME_W;
`endif

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic [FRAME_W-1:0] dct_buffer = '0;
    logic [COUNT_W-1:0] dct_count = '0;
    logic               dct_valid = 1'b0;
    logic               test_ending = 1'b0;
    logic               test_has_ended = 1'b0;
    logic               rd_ready = 1'b0;
    logic               rd_valid;
    logic [E-1:0]       rd_data;
    logic               rd_last;
    logic [4:0]         fill_level;
    logic               overflow;
    logic [7:0]         drop_count;
    logic               done;

    stepper_cpu_oci_dct_capture #(
        .FRAME_W(FRAME_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .dct_valid(dct_valid),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .fill_level(fill_level), .overflow(overflow),
        .drop_count(drop_count), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: trace queue plus phase 0=capture, 1=flush, 2=done.
    logic [E-1:0] mq[$];
    int           m_phase;
    int           m_drop;
    bit           m_ovf;
`ifdef OCI_CAPTURE_TIMESTAMP_EN
    logic [15:0]  m_ts;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [E-1:0] exp_data;
        bit           exp_valid;
        exp_valid = (mq.size() != 0) && (m_phase != 2);
        exp_data  = '0;
        if (exp_valid)
            exp_data = mq[0];
        chk("fill_level", 64'(fill_level), 64'(mq.size()));
        chk("rd_valid",   64'(rd_valid),   64'(exp_valid));
        chk("rd_data",    64'(rd_data),    64'(exp_data));
        chk("rd_last",    64'(rd_last),    64'(exp_valid && m_phase == 1 && mq.size() == 1));
        chk("overflow",   64'(overflow),   64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("done",       64'(done),       64'(m_phase == 2));
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_drop  = 0;
        m_ovf   = 1'b0;
`ifdef OCI_CAPTURE_TIMESTAMP_EN
        m_ts    = 16'd0;
`endif
    endtask

    // Advance the model by one clock using the inputs currently driven, then compare.
    task automatic cycle();
        logic [E-1:0] entry;
        bit           pop;
        bit           wr;
        int           size_before;
        pop = (mq.size() != 0) && (m_phase != 2) && rd_ready;
        size_before = mq.size();
`ifdef OCI_CAPTURE_TIMESTAMP_EN
        entry = {m_ts, dct_count, dct_buffer};
`else
        entry = {dct_count, dct_buffer};
`endif
        if (m_phase != 2) begin
            if (test_has_ended) begin
                mq.delete();
                m_phase = 2;
            end else begin
                wr = (m_phase == 0) && dct_valid && (dct_count != 0);
                if (pop)
                    void'(mq.pop_front());
                if (wr) begin
                    if (mq.size() < DEPTH)
                        mq.push_back(entry);
                    else begin
                        m_ovf = 1'b1;
                        if (m_drop < 255)
                            m_drop++;
                    end
                end
                if (m_phase == 0 && test_ending)
                    m_phase = 1;
                else if (m_phase == 1 && size_before == 0)
                    m_phase = 2;
            end
        end
`ifdef OCI_CAPTURE_TIMESTAMP_EN
        m_ts = m_ts + 16'd1;
`endif
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
        test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    endtask

    // Reset is dropped between edges so the asynchronous clear is observed before any clock.
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all();
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic frame(input bit v, input logic [COUNT_W-1:0] c, input logic [FRAME_W-1:0] d);
        dct_valid = v; dct_count = c; dct_buffer = d;
    endtask

    initial begin
        int pops;
        int lasts;
        #3;
        do_reset();

        // Basic write/read with consumer always ready
        rd_ready = 1'b1;
        frame(1, 4'd1, 30'h0000001);  cycle();
        chk("basic_d0", 64'(rd_data[COUNT_W+FRAME_W-1:0]), {30'h0, 4'd1, 30'h0000001});
        frame(1, 4'd15, 30'h2AAAAAAA); cycle();
        chk("basic_d1", 64'(rd_data[COUNT_W+FRAME_W-1:0]), {30'h0, 4'd15, 30'h2AAAAAAA});
        frame(1, 4'd3, 30'h3FFFFFFF);  cycle();
        chk("basic_d2", 64'(rd_data[COUNT_W+FRAME_W-1:0]), {30'h0, 4'd3, 30'h3FFFFFFF});
        frame(0, 4'd0, 30'h0);          cycle();
        chk("basic_empty", 64'(fill_level), 64'd0);

        // Empty frames are neither stored nor counted as drops
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            frame(1, 4'd0, 30'($urandom));
            cycle();
        end
        chk("filter_drop", 64'(drop_count), 64'd0);

        // Overflow: 20 writes into 16 entries, then write+pop while full
        for (int i = 0; i < 20; i++) begin
            frame(1, 4'($urandom_range(1, 15)), 30'($urandom));
            cycle();
        end
        chk("ovf_fill", 64'(fill_level), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drops", 64'(drop_count), 64'd4);
        rd_ready = 1'b1;
        frame(1, 4'd9, 30'h1234567);
        cycle();
        chk("full_wr_pop_fill", 64'(fill_level), 64'd16);
        chk("full_wr_pop_drop", 64'(drop_count), 64'd4);

        // Randomized capture traffic against the model
        for (int i = 0; i < 400; i++) begin
            frame($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 30'($urandom));
            rd_ready = $urandom_range(0, 2) == 0;
            cycle();
        end

        // Mid-operation asynchronous reset
        frame(1, 4'd5, 30'h155);
        rd_ready = 1'b0;
        cycle();
        do_reset();

        // drop_count saturates at 255
        for (int i = 0; i < 16 + 260; i++) begin
            frame(1, 4'd7, 30'($urandom));
            cycle();
        end
        chk("drop_saturate", 64'(drop_count), 64'd255);

        // Flush: three entries, then test_ending pulse and drain
        do_reset();
        for (int i = 0; i < 3; i++) begin
            frame(1, 4'($urandom_range(1, 15)), 30'($urandom));
            cycle();
        end
        frame(0, 4'd0, 30'h0);
        test_ending = 1'b1;
        cycle();
        test_ending = 1'b0;
        rd_ready = 1'b1;
        pops = 0;
        lasts = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (rd_valid) begin
                pops++;
                if (rd_last) begin
                    lasts++;
                    chk("flush_last_on_third", 64'(pops), 64'd3);
                end
            end
            cycle();
        end
        chk("flush_pops", 64'(pops), 64'd3);
        chk("flush_lasts", 64'(lasts), 64'd1);
        chk("flush_done", 64'(done), 64'd1);
        for (int i = 0; i < 3; i++) begin
            frame(1, 4'd2, 30'($urandom));
            cycle();
        end
        chk("done_ignores_writes", 64'(fill_level), 64'd0);

        // Abort with a sticky overflow already recorded
        do_reset();
        for (int i = 0; i < 18; i++) begin
            frame(1, 4'($urandom_range(1, 15)), 30'($urandom));
            cycle();
        end
        test_has_ended = 1'b1;
        test_ending = 1'b1;
        rd_ready = 1'b1;
        frame(1, 4'd4, 30'h777);
        cycle();
        chk("abort_fill", 64'(fill_level), 64'd0);
        chk("abort_valid", 64'(rd_valid), 64'd0);
        chk("abort_done", 64'(done), 64'd1);
        chk("abort_ovf", 64'(overflow), 64'd1);
        chk("abort_drops", 64'(drop_count), 64'd2);
        test_has_ended = 1'b0;
        test_ending = 1'b0;
        cycle();

        // An empty FIFO flushes straight through to done
        do_reset();
        test_ending = 1'b1;
        cycle();
        test_ending = 1'b0;
        cycle();
        chk("empty_flush_done", 64'(done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
